prim_ram_rr_arb: RTL
====================

// Module: prim_ram_rr_arb
// PURPOSE
// - Round-robin arbiter sharing one port of a 1-cycle-read-latency SRAM (prim_ram_2p
//   port A or B) between NumReq requesters.
// - Grants one request per cycle, drives the RAM port, returns read data to the
//   granted requester with a tagged rvalid.
// - Sits between host/DMA-style clients and a RAM port; one instance per shared port.
// PARAMETERS
// - NumReq  4    number of requesters, 2..16
// - Width   32   data width, bits
// - Depth   128  RAM words; Aw = $clog2(Depth) (localparam)
// - IdxW    -    localparam = $clog2(NumReq)
// PORTS
// - clk_i        in   1            single clock, all logic rising-edge
// - rst_i        in   1            synchronous, active-high reset
// - req_i        in   NumReq       per-requester request
// - write_i      in   NumReq       1 = write, 0 = read
// - addr_i       in   NumReq*Aw    packed addresses, requester k at [k*Aw +: Aw]
// - wdata_i      in   NumReq*Width packed write data
// - gnt_o        out  NumReq       one-hot grant, combinational, same cycle as ram_req_o
// - rvalid_o     out  NumReq       one-hot read-data-valid
// - rdata_o      out  Width        read data, shared, qualified by rvalid_o
// - ram_req_o    out  1            RAM port request
// - ram_write_o  out  1            RAM port write enable
// - ram_addr_o   out  Aw           RAM port address
// - ram_wdata_o  out  Width        RAM port write data
// - ram_rdata_i  in   Width        RAM read data, valid 1 cycle after read request
// BEHAVIOUR
// - Handshake: requester holds req/write/addr/wdata stable until gnt_o[k]=1; the
//   transfer happens in the gnt cycle. Dropping req before grant is allowed; the
//   request is then lost.
// - Arbitration: state = priority pointer ptr_q (IdxW bits). Grant the first asserted
//   req_i scanning k = ptr_q, ptr_q+1, ... mod NumReq.
// - ptr_q update: on any grant to k, ptr_q <= (k+1) mod NumReq, wrapping NumReq-1 -> 0.
//   No grant -> ptr_q unchanged.
// - At most one gnt_o bit per cycle; gnt_o = 0 when req_i = 0.
// - ram_req_o = |gnt_o.
// - ram_write_o/addr_o/wdata_o = granted requester's fields; all zero when no grant.
// - Read tracking: rd_pend_q and rd_idx_q register (grant & ~write) and the granted
//   index. Next cycle: rvalid_o[rd_idx_q] = rd_pend_q and rdata_o = ram_rdata_i.
//   rdata_o = 0 when no rvalid.
// - Writes produce no rvalid. Back-to-back reads (any requesters) give back-to-back
//   rvalid, latency 1.
// - A single persistent requester is granted every cycle. All NumReq requesting
//   continuously: each granted once per NumReq cycles.
// - Reset: ptr_q=0, rd_pend_q=0, rd_idx_q=0. Outputs during and after reset:
//   gnt_o=0, rvalid_o=0, rdata_o=0, ram_*_o=0.
// - Reset asserted mid-operation: an in-flight read's rvalid is suppressed (dropped).
//   Arbitration resumes from requester 0 on the first cycle after reset deasserts.
// - NumReq not a power of two: pointer wrap uses explicit compare, never undefined
//   indices.
// CONFIGURATION
// - PRIM_RAM_ARB_RDATA_REG_EN defined:
//   - extra output register on rvalid_o/rdata_o; read latency 2 cycles from grant
//   - register reset to 0 and also flushed by reset mid-operation
// - PRIM_RAM_ARB_RDATA_REG_EN undefined:
//   - latency 1, rdata_o driven combinationally from ram_rdata_i as described above
// TESTING
// - Reset then req_i=4'b0000 -> gnt_o=0, ram_req_o=0, rvalid_o=0 for 10 cycles.
// - req_i=4'b1111 held, all reads -> grant order 0,1,2,3,0,...
//   - rvalid_o order one cycle later (two with REG_EN)
//   - rdata_o matches preloaded RAM words
// - Requester 2 writes 0xDEADBEEF at addr 5, then requester 0 reads addr 5
//   -> rvalid_o=4'b0001, rdata_o=0xDEADBEEF.
// - ptr_q=3 with req_i=4'b1001 -> gnt_o=4'b1000; next cycle gnt_o=4'b0001
//   (wrap-around).
// - rst_i asserted the cycle after a read grant -> no rvalid_o pulse.
//   - first grant after reset goes to the lowest-index requester.
// - Random traffic, NumReq=3: scoreboard vs RAM model.
//   - no requester waits more than NumReq-1 cycles while holding req.
//   - never two grant bits set.

Source files
------------

// File: rtl/prim_ram_rr_arb.sv
// prim_ram_rr_arb: round-robin arbiter sharing one port of a 1-cycle-latency SRAM
// between NumReq requesters.
//
// One request is granted per cycle and routed to the RAM port. Read data comes back
// to the granted requester as a one-hot rvalid and a shared rdata bus.
//
// Optional build macro: PRIM_RAM_ARB_RDATA_REG_EN
//   defined   -> rvalid_o/rdata_o pass through an output register (read latency 2)
//   undefined -> rvalid_o/rdata_o come combinationally from ram_rdata_i (latency 1)
module prim_ram_rr_arb #(
    parameter  int NumReq = 4,
    parameter  int Width  = 32,
    parameter  int Depth  = 128,
    localparam int Aw     = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq-1:0]       write_i,
    input  logic [NumReq*Aw-1:0]    addr_i,
    input  logic [NumReq*Width-1:0] wdata_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic [NumReq-1:0]       rvalid_o,
    output logic [Width-1:0]        rdata_o,
    output logic                    ram_req_o,
    output logic                    ram_write_o,
    output logic [Aw-1:0]           ram_addr_o,
    output logic [Width-1:0]        ram_wdata_o,
    input  logic [Width-1:0]        ram_rdata_i
);

    localparam int IdxW = $clog2(NumReq);
    // One extra bit so ptr + offset never overflows before the modulo compare.
    localparam int CntW = IdxW + 1;

    logic [IdxW-1:0]   ptr_q;
    logic              rd_pend_q;
    logic [IdxW-1:0]   rd_idx_q;

    logic [NumReq-1:0] req_s;
    logic [NumReq-1:0] gnt_s;
    logic [IdxW-1:0]   gnt_idx_s;
    logic              gnt_any_s;
    logic [CntW-1:0]   cand_s;

    logic              ram_write_s;
    logic [Aw-1:0]     ram_addr_s;
    logic [Width-1:0]  ram_wdata_s;

    logic [NumReq-1:0] rvalid_s;
    logic [Width-1:0]  rdata_s;

    // No request is seen while reset is held, so nothing is granted then.
    assign req_s = rst_i ? {NumReq{1'b0}} : req_i;

    // Scan requesters starting at the priority pointer; the wrap uses an explicit
    // compare so non-power-of-two NumReq never forms an out-of-range index.
    always_comb begin
        gnt_s     = {NumReq{1'b0}};
        gnt_idx_s = {IdxW{1'b0}};
        gnt_any_s = 1'b0;
        cand_s    = {CntW{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            cand_s = {1'b0, ptr_q} + CntW'(i);
            if (cand_s >= CntW'(NumReq)) begin
                cand_s = cand_s - CntW'(NumReq);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_any_s && req_s[cand_s[IdxW-1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_s[IdxW-1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        gnt_s[gnt_idx_s] = gnt_any_s;
    end

    // Route the granted requester's fields to the RAM port; zero when idle.
    always_comb begin
        ram_write_s = 1'b0;
        ram_addr_s  = {Aw{1'b0}};
        ram_wdata_s = {Width{1'b0}};
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_s[k]) begin
                ram_write_s = write_i[k];
                ram_addr_s  = addr_i[k*Aw +: Aw];
                ram_wdata_s = wdata_i[k*Width +: Width];
            end else begin
                ram_write_s = ram_write_s;
            end
        end
    end

    // Advance the priority pointer past each winner and remember in-flight reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= {IdxW{1'b0}};
            rd_pend_q <= 1'b0;
            rd_idx_q  <= {IdxW{1'b0}};
        end else begin
            if (gnt_any_s) begin
                if (gnt_idx_s == IdxW'(NumReq - 1)) begin
                    ptr_q <= {IdxW{1'b0}};
                end else begin
                    ptr_q <= gnt_idx_s + IdxW'(1);
                end
            end else begin
                ptr_q <= ptr_q;
            end
            rd_pend_q <= gnt_any_s & ~ram_write_s;
            rd_idx_q  <= gnt_idx_s;
        end
    end

    // Steer returning RAM data to the requester whose read was granted last cycle;
    // a read still in flight when reset arrives is dropped here.
    always_comb begin
        rvalid_s = {NumReq{1'b0}};
        rdata_s  = {Width{1'b0}};
        if (rd_pend_q && !rst_i) begin
            rvalid_s[rd_idx_q] = 1'b1;
            rdata_s            = ram_rdata_i;
        end else begin
            rvalid_s = {NumReq{1'b0}};
            rdata_s  = {Width{1'b0}};
        end
    end

`ifdef PRIM_RAM_ARB_RDATA_REG_EN
    logic [NumReq-1:0] rvalid_q;
    logic [Width-1:0]  rdata_q;

    // Extra pipeline stage on the read return path; flushed by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= {NumReq{1'b0}};
            rdata_q  <= {Width{1'b0}};
        end else begin
            rvalid_q <= rvalid_s;
            rdata_q  <= rdata_s;
        end
    end

    assign rvalid_o = rst_i ? {NumReq{1'b0}} : rvalid_q;
    assign rdata_o  = rst_i ? {Width{1'b0}}  : rdata_q;
`else
    assign rvalid_o = rvalid_s;
    assign rdata_o  = rdata_s;
`endif

    assign gnt_o       = gnt_s;
    assign ram_req_o   = gnt_any_s;
    assign ram_write_o = ram_write_s;
    assign ram_addr_o  = ram_addr_s;
    assign ram_wdata_o = ram_wdata_s;

endmodule
